// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths and buffer geometry for the FIFO read-side adapter
package fifo_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int BUF_DEPTH = 3;
   localparam int PTR_W = 2;
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: valid/ready stream with packet last marker
interface fifo_stream_reader_if import fifo_pkg::*; #(parameter int DATA_WIDTH = DATA_WIDTH_DEF);
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;
   logic [DATA_WIDTH-1:0] m_data;
   modport master (output m_valid, m_data, m_last, input m_ready);
   modport slave (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 3-entry circular buffer with occupancy and write/read strobes
module stream_skid_buf import fifo_pkg::*; #(parameter int DATA_WIDTH = DATA_WIDTH_DEF) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [1:0]            occ
);
   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   assign rd_data = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (rd) rd_ptr <= ptr_inc(rd_ptr);
         occ <= occ + 2'(wr) - 2'(rd);
      end
   end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a synchronous FIFO and frames its words into a packetised valid/ready stream
module fifo_stream_reader import fifo_pkg::*; #(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PKT_LEN = 4,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_r_en,
   fifo_stream_reader_if.master  m,
   output logic                  pkt_done,
   output logic [CNT_W-1:0]      pkt_count
);
   logic             inflight;
   logic [1:0]       occ;
   logic [CNT_W-1:0] wcnt;
   logic             hs;
   // Reserving a slot for the in-flight word keeps m_ready out of the pop path
   assign fifo_r_en = enable & ~fifo_empty & (3'(occ) + 3'(inflight) < 3'(BUF_DEPTH));
   assign m.m_valid = occ != 2'd0;
   assign m.m_last = m.m_valid & (wcnt == CNT_W'(PKT_LEN - 1));
   assign hs = m.m_valid & m.m_ready;
   stream_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (inflight),
      .wr_data (fifo_data),
      .rd      (hs),
      .rd_data (m.m_data),
      .occ     (occ)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         wcnt <= '0;
         pkt_done <= 1'b0;
         pkt_count <= '0;
      end else begin
         inflight <= fifo_r_en;
         pkt_done <= hs & m.m_last;
         if (hs) wcnt <= m.m_last ? '0 : wcnt + CNT_W'(1);
         if (hs & m.m_last) pkt_count <= pkt_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scoreboard bench with an upstream FIFO model and directed packet scenarios
module tb_fifo_stream_reader;
   typedef struct {logic [7:0] d; logic l;} exp_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       push_en = 1'b0;
   logic [7:0] push_data = 8'h00;
   logic       fifo_empty;
   logic       fifo_r_en;
   logic [7:0] fifo_data;
   logic       pkt_done;
   logic [7:0] pkt_count;
   logic [7:0] mem [64];
   logic [5:0] rp, wp;
   int         pops;
   exp_t       sb[$];
   exp_t       e;
   int         checks = 0;
   int         fails = 0;
   int         delivered = 0;
   logic       prev_last = 1'b0;
   fifo_stream_reader_if #(.DATA_WIDTH(8)) sif ();
   fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(4), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_r_en  (fifo_r_en),
      .m          (sif.master),
      .pkt_done   (pkt_done),
      .pkt_count  (pkt_count)
   );
   always #5 clk = ~clk;
   // Upstream synchronous FIFO: registered read data, reset with the adapter
   assign fifo_empty = rp == wp;
   always @(posedge clk) begin
      if (!rst_n) begin
         rp <= '0;
         wp <= '0;
         fifo_data <= '0;
         pops <= 0;
      end else begin
         if (push_en) begin
            mem[wp] <= push_data;
            wp <= wp + 6'd1;
         end
         if (fifo_r_en && !fifo_empty) begin
            fifo_data <= mem[rp];
            rp <= rp + 6'd1;
            pops <= pops + 1;
         end
      end
   end
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rst_n) begin
         check("occ_plus_inflight_le_3", 32'(32'(dut.u_buf.occ) + 32'(dut.inflight) <= 3), 32'd1);
         check("pkt_done", 32'(pkt_done), 32'(prev_last));
         prev_last = sif.m_valid & sif.m_ready & sif.m_last;
         if (sif.m_valid && sif.m_ready) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_word: got %0h expected none", sif.m_data);
            end else begin
               e = sb.pop_front();
               check("m_data", 32'(sif.m_data), 32'(e.d));
               check("m_last", 32'(sif.m_last), 32'(e.l));
               delivered++;
            end
         end
      end else prev_last = 1'b0;
   end
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      enable = 1'b0;
      sif.m_ready = 1'b0;
      sb.delete();
      tick();
      rst_n = 1'b1;
   endtask
   task automatic push(input logic [7:0] d, input logic l, input logic expect_it = 1'b1);
      push_en = 1'b1;
      push_data = d;
      if (expect_it) sb.push_back('{d, l});
      tick();
      push_en = 1'b0;
   endtask
   task automatic wait_drain(input string name);
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         tick();
         t++;
      end
      check({name, "_drain"}, 32'(sb.size()), 32'd0);
      tick();
   endtask
   initial begin
      int t;
      int d0;
      sif.m_ready = 1'b0;
      do_reset();
      check("rst_m_valid", 32'(sif.m_valid), 32'd0);
      check("rst_m_last", 32'(sif.m_last), 32'd0);
      check("rst_pkt_done", 32'(pkt_done), 32'd0);
      check("rst_pkt_count", 32'(pkt_count), 32'd0);
      check("rst_m_data", 32'(sif.m_data), 32'd0);
      check("rst_fifo_r_en", 32'(fifo_r_en), 32'd0);
      // single packet, full rate
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h33, 1'b0);
      push(8'h44, 1'b1);
      sif.m_ready = 1'b1;
      enable = 1'b1;
      #1;
      check("t1_r_en", 32'(fifo_r_en), 32'd1);
      tick();
      check("t1_valid_after_pop", 32'(sif.m_valid), 32'd0);
      tick();
      check("t1_first_data", 32'(sif.m_data), 32'h11);
      for (int i = 0; i < 4; i++) begin
         check("t1_valid_run", 32'(sif.m_valid), 32'd1);
         tick();
      end
      check("t1_valid_end", 32'(sif.m_valid), 32'd0);
      check("t1_pkt_done", 32'(pkt_done), 32'd1);
      check("t1_pkt_count", 32'(pkt_count), 32'd1);
      wait_drain("t1");
      // backpressure then 12 back-to-back words
      do_reset();
      for (int i = 1; i <= 12; i++) push(8'(i), i % 4 == 0);
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (sif.m_valid) check("t2_hold_data", 32'(sif.m_data), 32'h01);
      end
      check("t2_pops", 32'(pops), 32'd3);
      check("t2_r_en", 32'(fifo_r_en), 32'd0);
      check("t2_occ", 32'(dut.u_buf.occ), 32'd3);
      sif.m_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         check("t2_b2b_valid", 32'(sif.m_valid), 32'd1);
         tick();
      end
      check("t2_pkt_count", 32'(pkt_count), 32'd3);
      wait_drain("t2");
      // toggling ready
      do_reset();
      for (int i = 1; i <= 8; i++) push(8'h80 + 8'(i), i % 4 == 0);
      enable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         sif.m_ready = (i % 2) == 0;
         tick();
      end
      sif.m_ready = 1'b1;
      wait_drain("t3");
      check("t3_pkt_count", 32'(pkt_count), 32'd2);
      // enable dropped mid-packet
      do_reset();
      push(8'hC1, 1'b0);
      push(8'hC2, 1'b0);
      push(8'hC3, 1'b0);
      push(8'hC4, 1'b1);
      sif.m_ready = 1'b1;
      d0 = delivered;
      enable = 1'b1;
      t = 0;
      while (pops < 2 && t < 20) begin
         tick();
         t++;
      end
      check("t4_two_pops", 32'(pops), 32'd2);
      enable = 1'b0;
      tick(8);
      check("t4_delivered", 32'(delivered - d0), 32'd2);
      check("t4_pops_held", 32'(pops), 32'd2);
      check("t4_m_last", 32'(sif.m_last), 32'd0);
      check("t4_pkt_count_mid", 32'(pkt_count), 32'd0);
      enable = 1'b1;
      wait_drain("t4");
      check("t4_pkt_count", 32'(pkt_count), 32'd1);
      // last word popped as FIFO empties
      do_reset();
      push(8'h5A, 1'b0);
      sif.m_ready = 1'b1;
      enable = 1'b1;
      #1;
      check("t5_r_en", 32'(fifo_r_en), 32'd1);
      tick();
      check("t5_empty", 32'(fifo_empty), 32'd1);
      check("t5_r_en_empty", 32'(fifo_r_en), 32'd0);
      tick();
      check("t5_valid", 32'(sif.m_valid), 32'd1);
      check("t5_r_en_empty2", 32'(fifo_r_en), 32'd0);
      tick();
      check("t5_valid_fall", 32'(sif.m_valid), 32'd0);
      check("t5_r_en_empty3", 32'(fifo_r_en), 32'd0);
      wait_drain("t5");
      // reset with buffered and in-flight words
      do_reset();
      for (int i = 1; i <= 5; i++) push(8'hA0 + 8'(i), 1'b0, 1'b0);
      enable = 1'b1;
      t = 0;
      while (!(dut.u_buf.occ == 2'd2 && dut.inflight) && t < 20) begin
         tick();
         t++;
      end
      check("t6_occ2_inflight", 32'(dut.u_buf.occ == 2'd2 && dut.inflight), 32'd1);
      rst_n = 1'b0;
      tick();
      check("t6_m_valid", 32'(sif.m_valid), 32'd0);
      check("t6_pkt_count", 32'(pkt_count), 32'd0);
      check("t6_wcnt", 32'(dut.wcnt), 32'd0);
      check("t6_m_data", 32'(sif.m_data), 32'd0);
      rst_n = 1'b1;
      sif.m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t6_no_stale_data", 32'(sif.m_data), 32'd0);
         check("t6_no_valid", 32'(sif.m_valid), 32'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side adapter that sits directly downstream of synchronous_fifo.
- Pops the FIFO through its r_en/empty interface and absorbs the FIFO's 1-cycle registered read latency.
- Presents a valid/ready stream to the consumer and frames it into fixed-length packets with a last marker.
- Holds a 3-entry local buffer so that full throughput (one word per cycle) is sustained with no combinational path from m_ready to fifo_r_en.

Parameters:
- DATA_WIDTH, 8, word width; must match the upstream FIFO.
- PKT_LEN, 4, words per packet; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the packet word counter and of the packet counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- enable  input  1  1 = issue FIFO reads; 0 = stop new reads, still drain buffered/in-flight words.
- fifo_empty  input  1  from FIFO empty.
- fifo_data  input  DATA_WIDTH  from FIFO data_out; valid the cycle after a pop.
- fifo_r_en  output  1  to FIFO r_en.
- m_valid  output  1  stream word valid.
- m_ready  input  1  consumer ready.
- m_data  output  DATA_WIDTH  stream word.
- m_last  output  1  final word of the current packet.
- pkt_done  output  1  one-cycle pulse, registered, the cycle after the m_last handshake.
- pkt_count  output  CNT_W  packets completed since reset; wraps modulo 2^CNT_W.

Behaviour:
- Pop definition: pop = fifo_r_en & !fifo_empty. fifo_r_en is driven only from registered state, plus fifo_empty and enable: fifo_r_en = enable & !fifo_empty & (occ + inflight < 3).
- inflight is a register set to pop; in the following cycle fifo_data is written into the buffer.
- Buffer: 3-entry circular buffer with wr_ptr, rd_ptr (2 bits, wrap 2->0) and occ (0..3).
- Buffer write: occurs when inflight = 1. Buffer read: occurs when m_valid & m_ready.
- Simultaneous write and read: occ is unchanged, both pointers advance.
- Overflow is impossible by construction. A bench assertion checks occ + inflight <= 3.
- m_valid = (occ != 0). m_data = buf[rd_ptr], driven from the buffer, never directly from fifo_data.
- First-word latency is 2 cycles: pop in cycle N, write in N+1, m_valid high in N+2.
- Steady-state throughput is 1 word per cycle when the FIFO is non-empty and m_ready is held high.
- Once m_valid is asserted, m_valid and m_data are held stable until the handshake.
- Word counter wcnt counts 0..PKT_LEN-1 and advances on each handshake, wrapping to 0 after PKT_LEN-1.
- m_last = m_valid & (wcnt == PKT_LEN-1). When PKT_LEN = 1, m_last = m_valid.
- A handshake with m_last high sets pkt_done for exactly the next cycle and increments pkt_count.
- enable deasserted mid-packet: no further pops. Buffered and in-flight words still drain. wcnt is retained, so the packet resumes when enable returns.
- fifo_empty rising while a word is in flight: the in-flight word is still captured. No pop is issued while empty.
- Reset (rst_n = 0 at a clock edge) clears occ, wr_ptr, rd_ptr, inflight, wcnt, pkt_done and pkt_count.
- Reset values: m_valid = 0, m_last = 0, pkt_done = 0, pkt_count = 0, m_data = 0 (buffer storage is cleared), fifo_r_en = 0.
- Reset mid-operation discards any in-flight word; the upstream FIFO is reset on the same rst_n.
- All state is updated in a single clocked process; combinational outputs are derived only from state, enable and fifo_empty.

Decomposition:
- Shared package (fifo_pkg) holds DATA_WIDTH defaults, the BUF_DEPTH = 3 constant and the buffer pointer width localparam.
- One natural sub-module: stream_skid_buf, the 3-entry buffer with occ and pointers and write/read strobes.
- The top level holds the pop/inflight logic, the packet counter and the pulse generation.

Test Plan:
- FIFO preloaded with 0x11,0x22,0x33,0x44, m_ready = 1, enable = 1:
  - first m_valid is 2 cycles after the first pop;
  - words appear on 4 consecutive cycles;
  - m_last is high on 0x44 only;
  - pkt_done pulses once; pkt_count = 1.
- 12 words preloaded, PKT_LEN = 4, m_ready held low for 10 cycles then high:
  - fifo_r_en stops after 3 pops; occ = 3 and m_data = first word, stable throughout;
  - then 12 words are delivered in order, back-to-back, with m_last on words 4, 8 and 12;
  - pkt_count = 3.
- m_ready toggling 1,0,1,0 with 8 words:
  - no loss or duplication; order is preserved;
  - occ + inflight never exceeds 3 (assertion).
- enable dropped after the 2nd pop of a 4-word packet:
  - exactly 2 words are delivered and m_last stays 0;
  - after enable is reasserted, words 3 and 4 follow and m_last is high on word 4.
- FIFO goes empty in the same cycle as a pop of its last word:
  - the word is still delivered;
  - fifo_r_en stays 0 while empty;
  - m_valid falls once that word is consumed.
- rst_n pulsed low for 1 cycle with occ = 2 and one word in flight:
  - next cycle m_valid = 0, pkt_count = 0, wcnt = 0;
  - the previously buffered data never appears on m_data.
